// File: rtl/rv32i_pkg.sv
// rv32i_pkg
// Shared RV32I pipeline constants used by the fetch stage and by the decode,
// immediate generation and hazard logic.
//   XLEN             datapath / address width (only 32 is supported)
//   NOP_INSTR        canonical bubble instruction, addi x0,x0,0
//   DEFAULT_RESET_PC PC loaded on reset unless a block overrides it
//   PC_STEP          byte distance between sequential instructions
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;

  // Sequential successor of a PC. The add wraps mod 2^32 and never traps.
  function automatic logic [XLEN-1:0] nextPc(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_id_fetch_stage_if.sv
// if_id_fetch_stage_if
// Bundles the fetch stage's instruction-memory bus and its IF/ID output bus.
//   imem_en_o     fetch -> imem  read request this cycle
//   imem_addr_o   fetch -> imem  read address
//   imem_rdata_i  imem -> fetch  word for the address requested last cycle
//   id_valid_o    fetch -> decode  IF/ID slot holds a real instruction
//   id_instr_o    fetch -> decode  instruction (NOP when the slot is a bubble)
//   id_pc_o       fetch -> decode  PC of id_instr_o
//   id_pc4_o      fetch -> decode  id_pc_o + 4, link value for JAL/JALR
// Modports: master = fetch stage, slave = memory / decode side.
interface if_id_fetch_stage_if;
  import rv32i_pkg::*;

  logic            imem_en_o;
  logic [XLEN-1:0] imem_addr_o;
  logic [XLEN-1:0] imem_rdata_i;
  logic            id_valid_o;
  logic [XLEN-1:0] id_instr_o;
  logic [XLEN-1:0] id_pc_o;
  logic [XLEN-1:0] id_pc4_o;

  modport master (
    output imem_en_o,
    output imem_addr_o,
    input  imem_rdata_i,
    output id_valid_o,
    output id_instr_o,
    output id_pc_o,
    output id_pc4_o
  );

  modport slave (
    input  imem_en_o,
    input  imem_addr_o,
    output imem_rdata_i,
    input  id_valid_o,
    input  id_instr_o,
    input  id_pc_o,
    input  id_pc4_o
  );

endinterface

// File: rtl/if_id_fetch_stage_skid.sv
// fetch_skid_buf
// One-entry holding register for an instruction-memory response that comes
// back while the IF/ID register is frozen by a stall.
//   clk      clock, rising edge
//   rst      synchronous active-high reset, empties the buffer
//   i_load   capture i_instr / i_pc and mark the entry valid
//   i_clear  empty the buffer (wins over i_load)
//   i_instr  instruction word to capture
//   i_pc     PC of that instruction
//   o_valid  buffer holds an instruction
//   o_instr  buffered instruction
//   o_pc     buffered PC
module fetch_skid_buf
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_clear,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc
);

  logic            r_valid;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;

  // Clearing beats loading so that a flush arriving in the same cycle as a
  // late response can never leave a stale instruction behind. Without a load
  // or clear the entry simply persists, which covers long stalls.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/if_id_fetch_stage.sv
// if_id_fetch_stage
// RV32I fetch stage plus IF/ID pipeline register. Holds the PC, issues reads
// to a synchronous instruction memory with one cycle of read latency, skids
// responses that arrive during a stall and presents instruction, PC and PC+4
// to decode.
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-high reset, overrides stall/redirect
//   stall_i        hazard unit: hold PC and IF/ID contents
//   redirect_i     EX-stage taken branch / jump: flush and refetch
//   redirect_pc_i  target PC when redirect_i is high
//   bus            imem request/response and IF/ID outputs (master side)
module if_id_fetch_stage #(
  parameter int                             XLEN      = rv32i_pkg::XLEN,
  parameter logic [rv32i_pkg::XLEN-1:0]     RESET_PC  = rv32i_pkg::DEFAULT_RESET_PC,
  parameter logic [rv32i_pkg::XLEN-1:0]     NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall_i,
  input  logic                       redirect_i,
  input  logic [rv32i_pkg::XLEN-1:0] redirect_pc_i,
  if_id_fetch_stage_if.master        bus
);

  localparam int W = rv32i_pkg::XLEN;

  logic [W-1:0] r_pc;
  logic         r_inflight;
  logic [W-1:0] r_inflightPc;

  logic         r_idValid;
  logic [W-1:0] r_idInstr;
  logic [W-1:0] r_idPc;
  logic [W-1:0] r_idPc4;

  logic         w_imemEn;
  logic         w_holdValid;
  logic [W-1:0] w_holdInstr;
  logic [W-1:0] w_holdPc;
  logic         w_srcValid;
  logic [W-1:0] w_srcInstr;
  logic [W-1:0] w_srcPc;
  logic         w_skidLoad;
  logic         w_skidClear;

  // A read is only worth issuing when its response will be consumed: not
  // during reset, not while frozen and not on the cycle the PC is replaced.
  assign w_imemEn = !rst && !stall_i && !redirect_i;

  // The skid buffer catches the response to the request issued just before
  // a stall began. Any unstalled cycle or a redirect drains/flushes it.
  assign w_skidLoad  = stall_i && !redirect_i && r_inflight;
  assign w_skidClear = redirect_i || !stall_i;

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skidLoad),
    .i_clear (w_skidClear),
    .i_instr (bus.imem_rdata_i),
    .i_pc    (r_inflightPc),
    .o_valid (w_holdValid),
    .o_instr (w_holdInstr),
    .o_pc    (w_holdPc)
  );

  // The buffered response is always older than anything in flight, so it
  // takes precedence when choosing what enters IF/ID.
  always_comb begin
    w_srcValid = 1'b0;
    w_srcInstr = NOP_INSTR;
    w_srcPc    = r_inflightPc;
    if (w_holdValid) begin
      w_srcValid = 1'b1;
      w_srcInstr = w_holdInstr;
      w_srcPc    = w_holdPc;
    end else if (r_inflight) begin
      w_srcValid = 1'b1;
      w_srcInstr = bus.imem_rdata_i;
      w_srcPc    = r_inflightPc;
    end
  end

  // PC, request tracking and the IF/ID register. Priority is reset, then
  // redirect, then stall, then normal advance. inflight only follows the
  // request strobe, so a response to a flushed or reset cycle is never
  // marked as pending and gets ignored when it arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_inflight   <= 1'b0;
      r_inflightPc <= RESET_PC;
      r_idValid    <= 1'b0;
      r_idInstr    <= NOP_INSTR;
      r_idPc       <= '0;
      r_idPc4      <= rv32i_pkg::PC_STEP;
    end else begin
      r_inflight   <= w_imemEn;
      r_inflightPc <= r_pc;
      if (redirect_i) begin
        r_pc      <= redirect_pc_i;
        r_idValid <= 1'b0;
        r_idInstr <= NOP_INSTR;
      end else if (!stall_i) begin
        r_pc      <= rv32i_pkg::nextPc(r_pc);
        r_idValid <= w_srcValid;
        r_idInstr <= w_srcInstr;
        r_idPc    <= w_srcPc;
        r_idPc4   <= rv32i_pkg::nextPc(w_srcPc);
      end
    end
  end

  // A buffered response and a fresh in-flight response at the same time
  // would mean one of them is about to be lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(w_holdValid && r_inflight))
        else $error("hold buffer and in-flight response both valid");
    end
  end

  assign bus.imem_en_o   = w_imemEn;
  assign bus.imem_addr_o = r_pc;
  assign bus.id_valid_o  = r_idValid;
  assign bus.id_instr_o  = r_idInstr;
  assign bus.id_pc_o     = r_idPc;
  assign bus.id_pc4_o    = r_idPc4;

endmodule
